regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between NUM_REQ writeback requesters (ALU, LSU, MDU) using round-robin arbitration with valid/ready handshakes.
- Registers the granted write onto the regfile write port.
- Keeps a per-register pending-write scoreboard so decode can stall or forward on rs1/rs2.
- Sits between the execute-stage units and the register file, alongside decode.

---
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of the writeback requesters onto the single register-file
// write port, with a pending-write scoreboard that decode uses to stall or forward.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wb_stall_i,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rs1_fwd,
  output logic                      rs2_fwd,
  output logic [DATA_W-1:0]         fwd_data,
  output logic                      rd_wren,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [PTR_W-1:0]    rr_ptr_r;
  logic [PTR_W-1:0]    rr_ptr_nxt_s;
  logic [PTR_W-1:0]    gnt_idx_s;
  logic                gnt_s;
  logic [ADDR_W-1:0]   gnt_addr_s;
  logic [DATA_W-1:0]   gnt_data_s;
  logic [NUM_REGS-1:0] busy_r;
  logic                rd_wren_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic [DATA_W-1:0]   rd_data_r;

  // Requester index base+offs modulo NUM_REQ; both operands are already below NUM_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
    int sum;
    sum = 32'(base) + offs;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  // Round-robin search from rr_ptr_r; the first valid requester wins.
  always_comb begin
    gnt_s     = 1'b0;
    gnt_idx_s = '0;
    if (!wb_stall_i && !rst_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_s && req_valid[wrap_add(rr_ptr_r, k)]) begin
          gnt_s     = 1'b1;
          gnt_idx_s = wrap_add(rr_ptr_r, k);
        end else begin
          gnt_s = gnt_s;
        end
      end
    end else begin
      gnt_s = 1'b0;
    end
  end

  // Grant decode: one-hot ready, selected payload and the pointer after this grant.
  always_comb begin
    req_ready    = '0;
    gnt_addr_s   = req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
    gnt_data_s   = req_data[gnt_idx_s*DATA_W +: DATA_W];
    rr_ptr_nxt_s = wrap_add(gnt_idx_s, 1);
    if (gnt_s) begin
      req_ready = NUM_REQ'(1) << gnt_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Arbitration pointer and the registered write port; x0 writes complete but never enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_r  <= '0;
      rd_wren_r <= 1'b0;
      rd_addr_r <= '0;
      rd_data_r <= '0;
    end else if (gnt_s) begin
      rr_ptr_r  <= rr_ptr_nxt_s;
      rd_wren_r <= (gnt_addr_s != '0);
      rd_addr_r <= gnt_addr_s;
      rd_data_r <= gnt_data_s;
    end else begin
      rd_wren_r <= 1'b0;
    end
  end

  // Pending-write scoreboard; the set is written last so it beats a same-edge commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r <= '0;
    end else begin
      if (rd_wren_r) begin
        busy_r[rd_addr_r] <= 1'b0;
      end
      if (issue_valid && (issue_addr != '0)) begin
        busy_r[issue_addr] <= 1'b1;
      end
    end
  end

  // Source lookup: a register being written this cycle forwards instead of stalling.
  always_comb begin
    rs1_fwd  = rd_wren_r && (rd_addr_r == rs1_addr) && (rs1_addr != '0);
    rs2_fwd  = rd_wren_r && (rd_addr_r == rs2_addr) && (rs2_addr != '0);
    rs1_busy = busy_r[rs1_addr] && !rs1_fwd;
    rs2_busy = busy_r[rs2_addr] && !rs2_fwd;
    fwd_data = rd_data_r;
    rd_wren  = rd_wren_r;
    rd_addr  = rd_addr_r;
    rd_data  = rd_data_r;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a cycle model checked every cycle plus
// hand-computed expectations at the interesting points of each scenario.
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      wb_stall_i;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      issue_valid;
  logic [ADDR_W-1:0]         issue_addr;
  logic [ADDR_W-1:0]         rs1_addr;
  logic [ADDR_W-1:0]         rs2_addr;
  logic                      rs1_busy, rs2_busy, rs1_fwd, rs2_fwd;
  logic [DATA_W-1:0]         fwd_data;
  logic                      rd_wren;
  logic [ADDR_W-1:0]         rd_addr;
  logic [DATA_W-1:0]         rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_stall_i(wb_stall_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .fwd_data(fwd_data), .rd_wren(rd_wren), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Model state: arbitration pointer, pending-register set, last write on the port.
  int                m_ptr = 0, n_ptr = 0;
  logic [31:0]       m_busy = '0, n_busy = '0;
  logic              m_wren = 1'b0, n_wren = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0, n_addr = '0;
  logic [DATA_W-1:0] m_data = '0, n_data = '0;
  bit                m_known = 1'b0, n_known = 1'b0;
  int                gi;
  logic [NUM_REQ-1:0] e_ready;
  logic              e_f1, e_f2, e_b1, e_b2;

  always @(negedge clk_i) begin
    gi = -1;
    if (!rst_i && !wb_stall_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (gi < 0 && req_valid[(m_ptr + k) % NUM_REQ]) gi = (m_ptr + k) % NUM_REQ;
      end
    end
    e_ready = '0;
    if (gi >= 0) e_ready[gi] = 1'b1;
    e_f1 = m_wren && m_addr == rs1_addr && rs1_addr != 0;
    e_f2 = m_wren && m_addr == rs2_addr && rs2_addr != 0;
    e_b1 = m_busy[rs1_addr] && !e_f1;
    e_b2 = m_busy[rs2_addr] && !e_f2;
    if (m_known) begin
      chk("model_ready", req_ready, e_ready);
      chk("model_wren", rd_wren, m_wren);
      chk("model_addr", rd_addr, m_addr);
      chk("model_data", rd_data, m_data);
      chk("model_fwd_data", fwd_data, m_data);
      chk("model_rs1_fwd", rs1_fwd, e_f1);
      chk("model_rs2_fwd", rs2_fwd, e_f2);
      chk("model_rs1_busy", rs1_busy, e_b1);
      chk("model_rs2_busy", rs2_busy, e_b2);
    end
    if (rst_i) begin
      n_ptr = 0; n_busy = '0; n_wren = 1'b0; n_addr = '0; n_data = '0; n_known = 1'b1;
    end else begin
      n_known = m_known;
      n_busy  = m_busy;
      if (m_wren) n_busy[m_addr] = 1'b0;
      if (issue_valid && issue_addr != 0) n_busy[issue_addr] = 1'b1;
      n_ptr = m_ptr; n_addr = m_addr; n_data = m_data; n_wren = 1'b0;
      if (gi >= 0) begin
        n_ptr  = (gi + 1) % NUM_REQ;
        n_addr = req_addr[gi*ADDR_W +: ADDR_W];
        n_data = req_data[gi*DATA_W +: DATA_W];
        n_wren = (n_addr != 0);
      end
    end
  end

  always @(posedge clk_i) begin
    m_ptr   <= n_ptr;
    m_busy  <= n_busy;
    m_wren  <= n_wren;
    m_addr  <= n_addr;
    m_data  <= n_data;
    m_known <= n_known;
  end

  logic [NUM_REQ-1:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [ADDR_W-1:0]  rr_addr_exp [5] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2};

  initial begin
    rst_i = 1'b1; wb_stall_i = 1'b0; req_valid = 3'b111;
    issue_valid = 1'b0; issue_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    req_addr = '0; req_data = '0;
    set_req(0, 5'd1, 32'hA000_0000);
    set_req(1, 5'd2, 32'hB111_1111);
    set_req(2, 5'd3, 32'hC222_2222);
    for (int c = 0; c < 2; c++) begin
      mid();
      chk("rst_ready", req_ready, 32'd0);
      chk("rst_wren", rd_wren, 32'd0);
      chk("rst_rs1_busy", rs1_busy, 32'd0);
      chk("rst_rs2_busy", rs2_busy, 32'd0);
      cyc();
    end

    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("rr_ready", req_ready, rr_exp[i]);
      if (i > 0) begin
        chk("rr_wren", rd_wren, 32'd1);
        chk("rr_addr", rd_addr, rr_addr_exp[i-1]);
      end
      cyc();
    end

    wb_stall_i = 1'b1; req_valid = 3'b010;
    mid();
    chk("last_rr_wren", rd_wren, 32'd1);
    chk("last_rr_data", rd_data, 32'hC222_2222);
    chk("stall_ready", req_ready, 32'd0);
    cyc();
    for (int c = 0; c < 2; c++) begin
      mid();
      chk("stall_ready", req_ready, 32'd0);
      chk("stall_wren", rd_wren, 32'd0);
      cyc();
    end

    wb_stall_i = 1'b0;
    mid();
    chk("unstall_ready", req_ready, 32'b010);
    cyc();
    set_req(1, 5'd0, 32'hDEAD_BEEF);
    mid();
    chk("x0_ready", req_ready, 32'b010);
    chk("unstall_addr", rd_addr, 32'd2);
    cyc();

    req_valid = 3'b000; issue_valid = 1'b1; issue_addr = 5'd5;
    mid();
    chk("x0_wren", rd_wren, 32'd0);
    chk("x0_data", rd_data, 32'hDEAD_BEEF);
    cyc();

    issue_valid = 1'b0; rs1_addr = 5'd5; req_valid = 3'b010;
    set_req(1, 5'd5, 32'h0000_1234);
    mid();
    chk("issue_busy", rs1_busy, 32'd1);
    chk("lsu_ready", req_ready, 32'b010);
    cyc();
    req_valid = 3'b000;
    mid();
    chk("x5_fwd", rs1_fwd, 32'd1);
    chk("x5_busy_fwd", rs1_busy, 32'd0);
    chk("x5_fwd_data", fwd_data, 32'h0000_1234);
    cyc();

    req_valid = 3'b001; set_req(0, 5'd7, 32'h0000_0077);
    issue_valid = 1'b1; issue_addr = 5'd7;
    mid();
    chk("post_commit_busy", rs1_busy, 32'd0);
    chk("post_commit_fwd", rs1_fwd, 32'd0);
    cyc();
    req_valid = 3'b000; rs1_addr = 5'd7;
    mid();
    chk("x7_fwd", rs1_fwd, 32'd1);
    chk("x7_wren", rd_wren, 32'd1);
    cyc();

    issue_valid = 1'b0; rs2_addr = 5'd5; req_valid = 3'b100;
    set_req(2, 5'd3, 32'h0000_0033);
    mid();
    chk("set_wins_busy", rs1_busy, 32'd1);
    chk("x5_rs2_busy", rs2_busy, 32'd0);
    chk("x3_ready", req_ready, 32'b100);
    cyc();

    rst_i = 1'b1; req_valid = 3'b111;
    mid();
    chk("x3_wren_pending", rd_wren, 32'd1);
    chk("rst_mid_ready", req_ready, 32'd0);
    cyc();
    rst_i = 1'b0; req_valid = 3'b000; issue_valid = 1'b1; issue_addr = 5'd3; rs2_addr = 5'd3;
    mid();
    chk("rst_mid_wren", rd_wren, 32'd0);
    chk("rst_mid_busy7", rs1_busy, 32'd0);
    chk("rst_mid_busy3", rs2_busy, 32'd0);
    cyc();
    issue_valid = 1'b0;
    mid();
    chk("reissue_busy", rs2_busy, 32'd1);
    cyc();
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
